// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a streaming FFT datapath with fixed latency LAT: input framing,
// sof delay line, output burst counter. Define FFT_FRAME_BITREV_EN for bit-reversed out_idx_o.
module fft_frame_ctrl #(
  parameter int N   = 32,
  parameter int LAT = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 flush_i,
  output logic                 ready_o,
  output logic                 sof_o,
  output logic                 stage_en_o,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] out_idx_o,
  output logic                 eof_o,
  output logic [7:0]           frame_cnt_o,
  output logic                 err_o
);
  localparam int            IW   = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  typedef enum logic [1:0] {IDLE, LOAD, ERR} state_t;

  state_t         state, state_n;
  logic [IW-1:0]  in_cnt, in_cnt_n, out_cnt, out_cnt_n, idx_n;
  logic [LAT-1:0] sof_pipe, drop, keep, pipe_n;
  logic           rdy_q, accept, sof_n, gap, dsof, valid_n, eof_n, stage_n;

  // rdy_q holds ready low until the first edge after reset release
  assign ready_o = rdy_q && (state != ERR) && !flush_i;
  assign accept  = valid_i && ready_o;

  // in_cnt is the index of the sample expected this cycle; 0 in LOAD means a frame just closed
  always_comb begin
    state_n  = state;
    in_cnt_n = in_cnt;
    sof_n    = 1'b0;
    gap      = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_n  = LOAD;
        in_cnt_n = IW'(1);
        sof_n    = 1'b1;
      end
      LOAD: if (in_cnt == '0) begin
        if (accept) begin
          in_cnt_n = IW'(1);
          sof_n    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end else if (accept) begin
        in_cnt_n = in_cnt + 1'b1;
      end else begin
        gap      = 1'b1;
        state_n  = ERR;
        in_cnt_n = '0;
      end
      ERR: if (sof_pipe == '0 && !valid_o) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The partial frame's sof entered the pipe in_cnt edges ago, so it now sits at in_cnt-1
  always_comb begin
    drop = '0;
    for (int i = 0; i < LAT; i++)
      if (gap && int'(in_cnt) == i + 1) drop[i] = 1'b1;
  end

  assign keep = sof_pipe & ~drop;
  assign dsof = keep[LAT-1];

  always_comb begin
    pipe_n    = keep << 1;
    pipe_n[0] = sof_n;
  end

  // A delayed sof always restarts the burst, which chains back-to-back frames seamlessly
  always_comb begin
    valid_n   = valid_o;
    out_cnt_n = out_cnt;
    if (dsof) begin
      valid_n   = 1'b1;
      out_cnt_n = '0;
    end else if (valid_o) begin
      if (out_cnt == LAST) begin
        valid_n   = 1'b0;
        out_cnt_n = '0;
      end else begin
        out_cnt_n = out_cnt + 1'b1;
      end
    end
  end

  assign eof_n   = valid_n && (out_cnt_n == LAST);
  assign stage_n = (state_n == LOAD) || (pipe_n != '0) || valid_n;

`ifdef FFT_FRAME_BITREV_EN
  always_comb begin
    idx_n = '0;
    for (int i = 0; i < IW; i++) idx_n[i] = out_cnt_n[IW-1-i];
  end
`else
  assign idx_n = out_cnt_n;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      sof_pipe    <= '0;
      rdy_q       <= 1'b0;
      sof_o       <= 1'b0;
      stage_en_o  <= 1'b0;
      valid_o     <= 1'b0;
      out_idx_o   <= '0;
      eof_o       <= 1'b0;
      frame_cnt_o <= '0;
      err_o       <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (flush_i) begin
        state      <= IDLE;
        in_cnt     <= '0;
        out_cnt    <= '0;
        sof_pipe   <= '0;
        sof_o      <= 1'b0;
        stage_en_o <= 1'b0;
        valid_o    <= 1'b0;
        out_idx_o  <= '0;
        eof_o      <= 1'b0;
      end else begin
        state       <= state_n;
        in_cnt      <= in_cnt_n;
        out_cnt     <= out_cnt_n;
        sof_pipe    <= pipe_n;
        sof_o       <= sof_n;
        stage_en_o  <= stage_n;
        valid_o     <= valid_n;
        out_idx_o   <= idx_n;
        eof_o       <= eof_n;
        frame_cnt_o <= frame_cnt_o + {7'd0, eof_o};
        err_o       <= err_o | gap;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl (N=32, LAT=40). Cycle t = outputs sampled after rising edge t,
// with inputs for edge t driven on the preceding falling edge.
module tb_fft_frame_ctrl;
  localparam int MAXC = 160;

  logic       clk, rst, valid_i, flush_i;
  logic       ready_o, sof_o, stage_en_o, valid_o, eof_o, err_o;
  logic [4:0] out_idx_o;
  logic [7:0] frame_cnt_o;

  int n_chk = 0;
  int n_fail = 0;

  logic       v_stim[MAXC], f_stim[MAXC], r_stim[MAXC];
  logic       o_v[MAXC], o_sof[MAXC], o_eof[MAXC], o_rdy[MAXC], o_stage[MAXC], o_err[MAXC];
  logic [4:0] o_idx[MAXC];

  fft_frame_ctrl #(.N(32), .LAT(40)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
    .ready_o(ready_o), .sof_o(sof_o), .stage_en_o(stage_en_o), .valid_o(valid_o),
    .out_idx_o(out_idx_o), .eof_o(eof_o), .frame_cnt_o(frame_cnt_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] exp_idx(input int k);
    logic [4:0] c, r;
    c = k[4:0];
    r = c;
`ifdef FFT_FRAME_BITREV_EN
    for (int i = 0; i < 5; i++) r[i] = c[4-i];
`endif
    return r;
  endfunction

  task automatic clear_stim();
    for (int t = 0; t < MAXC; t++) begin
      v_stim[t] = 1'b0; f_stim[t] = 1'b0; r_stim[t] = 1'b1;
    end
  endtask

  task automatic run(input int ncyc);
    for (int t = 0; t < ncyc; t++) begin
      valid_i = v_stim[t]; flush_i = f_stim[t]; rst = r_stim[t];
      @(negedge clk);
      o_v[t] = valid_o; o_sof[t] = sof_o; o_eof[t] = eof_o; o_rdy[t] = ready_o;
      o_stage[t] = stage_en_o; o_err[t] = err_o; o_idx[t] = out_idx_o;
    end
    valid_i = 1'b0; flush_i = 1'b0; rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({ready_o, sof_o, stage_en_o, valid_o, eof_o, err_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {ready_o, sof_o, stage_en_o, valid_o, eof_o, err_o});
    end
    n_chk++;
    if (out_idx_o !== 5'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", out_idx_o); end
    n_chk++;
    if (frame_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt_o); end
    rst = 1'b1;
    #1;
    n_chk++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", ready_o); end
    @(negedge clk);
    n_chk++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", ready_o); end
  endtask

  task automatic test_single();
    int bv, bi, bs, be, bo, fb, fc0;
    clear_stim();
    for (int t = 0; t < 32; t++) v_stim[t] = 1'b1;
    fc0 = int'(frame_cnt_o);
    run(80);
    bv = 0; bi = 0; bs = 0; be = 0; bo = 0; fb = -1;
    for (int t = 0; t < 80; t++) begin
      if (o_v[t] !== (t >= 40 && t <= 71)) begin bv++; if (fb < 0) fb = t; end
      if (o_v[t] && o_idx[t] !== exp_idx(t - 40)) bi++;
      if (o_stage[t] !== (t <= 71)) bs++;
      if (o_eof[t] !== (t == 71)) be++;
      if (o_sof[t] !== (t == 0)) bo++;
    end
    n_chk++; if (bv !== 0) begin n_fail++; $display("FAIL single_valid: %0d bad cycles first %0d want window 40..71", bv, fb); end
    n_chk++; if (bi !== 0) begin n_fail++; $display("FAIL single_idx: %0d bad indices want 0", bi); end
    n_chk++; if (bs !== 0) begin n_fail++; $display("FAIL single_stage_en: %0d bad cycles want 0", bs); end
    n_chk++; if (be !== 0) begin n_fail++; $display("FAIL single_eof: %0d bad cycles want eof only at 71", be); end
    n_chk++; if (bo !== 0) begin n_fail++; $display("FAIL single_sof: %0d bad cycles want sof only at 0", bo); end
    n_chk++;
    if (frame_cnt_o !== 8'(fc0 + 1)) begin n_fail++; $display("FAIL single_frame_cnt: got %0d want %0d", frame_cnt_o, fc0 + 1); end
  endtask

  task automatic test_back_to_back();
    int bv, bi, be, bo, fb, fc0;
    clear_stim();
    for (int t = 0; t < 96; t++) v_stim[t] = 1'b1;
    fc0 = int'(frame_cnt_o);
    run(150);
    bv = 0; bi = 0; be = 0; bo = 0; fb = -1;
    for (int t = 0; t < 150; t++) begin
      if (o_v[t] !== (t >= 40 && t <= 135)) begin bv++; if (fb < 0) fb = t; end
      if (o_v[t] && o_idx[t] !== exp_idx(t - 40)) bi++;
      if (o_eof[t] !== (t == 71 || t == 103 || t == 135)) be++;
      if (o_sof[t] !== (t == 0 || t == 32 || t == 64)) bo++;
    end
    n_chk++; if (bv !== 0) begin n_fail++; $display("FAIL b2b_valid: %0d bad cycles first %0d want window 40..135", bv, fb); end
    n_chk++; if (bi !== 0) begin n_fail++; $display("FAIL b2b_idx: %0d bad indices want 0", bi); end
    n_chk++; if (be !== 0) begin n_fail++; $display("FAIL b2b_eof: %0d bad cycles want eof at 71,103,135", be); end
    n_chk++; if (bo !== 0) begin n_fail++; $display("FAIL b2b_sof: %0d bad cycles want sof at 0,32,64", bo); end
    n_chk++;
    if (frame_cnt_o !== 8'(fc0 + 3)) begin n_fail++; $display("FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt_o, fc0 + 3); end
  endtask

  task automatic test_gap();
    int bv, br, bo, be, fb, fc0;
    clear_stim();
    for (int t = 0; t < 42; t++) v_stim[t] = 1'b1;
    for (int t = 50; t < 53; t++) v_stim[t] = 1'b1;
    fc0 = int'(frame_cnt_o);
    run(90);
    bv = 0; br = 0; bo = 0; be = 0; fb = -1;
    for (int t = 0; t < 90; t++) begin
      if (o_v[t] !== (t >= 40 && t <= 71)) begin bv++; if (fb < 0) fb = t; end
      if ((t < 42 || t >= 80) && o_rdy[t] !== 1'b1) br++;
      if (t >= 42 && t <= 71 && o_rdy[t] !== 1'b0) br++;
      if (o_sof[t] !== (t == 0 || t == 32)) bo++;
      if (o_err[t] !== (t >= 42)) be++;
    end
    n_chk++; if (bv !== 0) begin n_fail++; $display("FAIL gap_valid: %0d bad cycles first %0d want window 40..71", bv, fb); end
    n_chk++; if (br !== 0) begin n_fail++; $display("FAIL gap_ready: %0d bad cycles want 0", br); end
    n_chk++; if (bo !== 0) begin n_fail++; $display("FAIL gap_sof: %0d bad cycles want sof at 0,32", bo); end
    n_chk++; if (be !== 0) begin n_fail++; $display("FAIL gap_err: %0d bad cycles want err from 42", be); end
    n_chk++;
    if (frame_cnt_o !== 8'(fc0 + 1)) begin n_fail++; $display("FAIL gap_frame_cnt: got %0d want %0d", frame_cnt_o, fc0 + 1); end
    n_chk++; if (stage_en_o !== 1'b0) begin n_fail++; $display("FAIL gap_stage_idle: got %b want 0", stage_en_o); end
  endtask

  task automatic test_flush();
    int bv, br, bs, bo, fb, fc0;
    clear_stim();
    for (int t = 0; t < 32; t++) v_stim[t] = 1'b1;
    f_stim[51] = 1'b1;
    v_stim[60] = 1'b1; f_stim[60] = 1'b1;
    fc0 = int'(frame_cnt_o);
    run(100);
    bv = 0; br = 0; bs = 0; bo = 0; fb = -1;
    for (int t = 0; t < 100; t++) begin
      if (o_v[t] !== (t >= 40 && t <= 50)) begin bv++; if (fb < 0) fb = t; end
      if (o_rdy[t] !== !(t == 51 || t == 60)) br++;
      if (o_stage[t] !== (t <= 50)) bs++;
      if (o_sof[t] !== (t == 0)) bo++;
    end
    n_chk++; if (bv !== 0) begin n_fail++; $display("FAIL flush_valid: %0d bad cycles first %0d want window 40..50", bv, fb); end
    n_chk++; if (br !== 0) begin n_fail++; $display("FAIL flush_ready: %0d bad cycles want 0", br); end
    n_chk++; if (bs !== 0) begin n_fail++; $display("FAIL flush_stage_en: %0d bad cycles want 0", bs); end
    n_chk++; if (bo !== 0) begin n_fail++; $display("FAIL flush_sof: %0d bad cycles want sof only at 0", bo); end
    n_chk++;
    if (frame_cnt_o !== 8'(fc0)) begin n_fail++; $display("FAIL flush_frame_cnt: got %0d want %0d", frame_cnt_o, fc0); end
    n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL flush_err_kept: got %b want 1", err_o); end
    n_chk++; if (out_idx_o !== 5'd0) begin n_fail++; $display("FAIL flush_idx: got %0d want 0", out_idx_o); end
  endtask

  task automatic test_reset_mid();
    int bv, bi, br, bo, be, fb;
    clear_stim();
    for (int t = 0; t < 20; t++) v_stim[t] = 1'b1;
    for (int t = 20; t < 25; t++) r_stim[t] = 1'b0;
    for (int t = 30; t < 62; t++) v_stim[t] = 1'b1;
    run(110);
    bv = 0; bi = 0; br = 0; bo = 0; be = 0; fb = -1;
    for (int t = 0; t < 110; t++) begin
      if (o_v[t] !== (t >= 70 && t <= 101)) begin bv++; if (fb < 0) fb = t; end
      if (o_v[t] && o_idx[t] !== exp_idx(t - 70)) bi++;
      if (o_rdy[t] !== !(t >= 20 && t <= 24)) br++;
      if (o_sof[t] !== (t == 0 || t == 30)) bo++;
      if (t >= 20 && o_err[t] !== 1'b0) be++;
    end
    n_chk++; if (bv !== 0) begin n_fail++; $display("FAIL rstmid_valid: %0d bad cycles first %0d want window 70..101", bv, fb); end
    n_chk++; if (bi !== 0) begin n_fail++; $display("FAIL rstmid_idx: %0d bad indices want 0", bi); end
    n_chk++; if (br !== 0) begin n_fail++; $display("FAIL rstmid_ready: %0d bad cycles want 0", br); end
    n_chk++; if (bo !== 0) begin n_fail++; $display("FAIL rstmid_sof: %0d bad cycles want sof at 0,30", bo); end
    n_chk++; if (be !== 0) begin n_fail++; $display("FAIL rstmid_err_cleared: %0d bad cycles want 0", be); end
    n_chk++; if (frame_cnt_o !== 8'd1) begin n_fail++; $display("FAIL rstmid_frame_cnt: got %0d want 1", frame_cnt_o); end
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
